// File: rtl/count_snapshot_fifo_if.sv
// Output handshake bundle for count_snapshot_fifo: head entry plus valid/ready.
// The FIFO drives the master side; the drain/display logic uses the slave side.
interface count_snapshot_fifo_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/count_snapshot_fifo.sv
// Extends an 8-bit activity count to 16 bits by counting overflow pulses into a
// high byte, and snapshots the extended count into a small first-word-fall-through
// FIFO on each capture request. Snapshots arriving while full are counted as drops.
module count_snapshot_fifo #(
    parameter  int CNT_W = 8,
    parameter  int EXT_W = 8,
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CNT_W-1:0]      cnt_in,
    input  logic                  ovf_in,
    input  logic                  snap_req,
    input  logic                  clr,
    count_snapshot_fifo_if.master out_if,
    output logic                  full,
    output logic                  empty,
    output logic [LVL_W-1:0]      level,
    output logic [7:0]            drop_cnt
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int DATA_W = EXT_W + CNT_W;

    logic [EXT_W-1:0]  r_ext;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_full;
    logic              r_empty;
    logic [7:0]        r_drop_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [EXT_W-1:0]  w_ext_eff;
    logic [DATA_W-1:0] w_snap;
    logic [LVL_W-1:0]  w_level_next;

    // Handshake decode; clr overrides everything. A pop frees a slot in the same
    // cycle, so a full FIFO still accepts a snapshot while it is being drained.
    assign w_pop  = ~r_empty & out_if.out_ready & ~clr;
    assign w_push = snap_req & ~clr & (~r_full | w_pop);
    assign w_drop = snap_req & ~clr & r_full & ~w_pop;

    // An overflow in the capture cycle already counts toward the high byte,
    // keeping captured values monotonic across a counter wrap.
    assign w_ext_eff = ovf_in ? r_ext + 1'b1 : r_ext;
    assign w_snap    = {w_ext_eff, cnt_in};

    // Occupancy after this edge.
    always_comb begin
        w_level_next = r_level;
        if (clr) begin
            w_level_next = '0;
        end else if (w_push && !w_pop) begin
            w_level_next = r_level + 1'b1;
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - 1'b1;
        end
    end

    // Overflow-extension register: counts overflow pulses, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext <= '0;
        end else if (clr) begin
            r_ext <= '0;
        end else if (ovf_in) begin
            r_ext <= r_ext + 1'b1;
        end
    end

    // Pointers, level and flags all move on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_next;
            r_full  <= (w_level_next == LVL_W'(DEPTH));
            r_empty <= (w_level_next == '0);
        end
    end

    // Saturating count of snapshots discarded because the FIFO was full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (clr) begin
            r_drop_cnt <= '0;
        end else if (w_drop && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    // Storage array; contents need no reset because the output is gated by valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_snap;
        end
    end

    assign out_if.out_valid = ~r_empty;
    assign out_if.out_data  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign full             = r_full;
    assign empty            = r_empty;
    assign level            = r_level;
    assign drop_cnt         = r_drop_cnt;
endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench for count_snapshot_fifo with a queue scoreboard: expected
// snapshots are queued when a capture is accepted and compared when popped.
module tb_count_snapshot_fifo;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cnt_in = '0;
    logic        ovf_in = 1'b0;
    logic        snap_req = 1'b0;
    logic        clr = 1'b0;
    logic        full, empty;
    logic [2:0]  level;
    logic [7:0]  drop_cnt;

    count_snapshot_fifo_if #(.DATA_W(16)) u_if ();

    count_snapshot_fifo #(.CNT_W(8), .EXT_W(8), .DEPTH(DEPTH)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_in   (cnt_in),
        .ovf_in   (ovf_in),
        .snap_req (snap_req),
        .clr      (clr),
        .out_if   (u_if),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  m_ext = '0;
    logic [7:0]  m_drop = '0;
    logic [15:0] last_pop = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(exp_q.size()));
        chk({tag, ".full"}, 32'(full), 32'(exp_q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
        chk({tag, ".valid"}, 32'(u_if.out_valid), 32'(exp_q.size() != 0));
        chk({tag, ".drop"}, 32'(drop_cnt), 32'(m_drop));
        if (exp_q.size() != 0)
            chk({tag, ".head"}, 32'(u_if.out_data), 32'(exp_q[0]));
    endtask

    // One clock: drive inputs, update the model, step the edge, check state.
    task automatic cyc(input logic snap, input logic [7:0] cnt, input logic ovf,
                       input logic rdy, input logic clr_i, input bit verbose);
        logic        pop, push, was_full;
        logic [7:0]  eff;
        snap_req = snap; cnt_in = cnt; ovf_in = ovf; u_if.out_ready = rdy; clr = clr_i;
        if (clr_i) begin
            exp_q.delete();
            m_ext  = '0;
            m_drop = '0;
        end else begin
            was_full = (exp_q.size() == DEPTH);
            pop      = (exp_q.size() != 0) && rdy;
            if (pop) begin
                last_pop = exp_q.pop_front();
                chk("pop_data", 32'(u_if.out_data), 32'(last_pop));
                $display("[TB] pop  data=%04h", u_if.out_data);
            end
            push = snap && (!was_full || pop);
            eff  = ovf ? m_ext + 8'd1 : m_ext;
            if (push) begin
                exp_q.push_back({eff, cnt});
                if (verbose) $display("[TB] push data=%04h", {eff, cnt});
            end else if (snap && m_drop != 8'hFF) begin
                m_drop++;
            end
            if (ovf) m_ext++;
        end
        @(posedge clk);
        #1;
        if (verbose) chk_state("cyc");
    endtask

    initial begin
        u_if.out_ready = 1'b0;
        #12;
        chk("rst.valid", 32'(u_if.out_valid), 0);
        chk("rst.data", 32'(u_if.out_data), 0);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.full", 32'(full), 0);
        chk("rst.level", 32'(level), 0);
        chk("rst.drop", 32'(drop_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three overflows, then a capture of 0x2A; drain it.
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 1, 0, 1);
        cyc(1, 8'h2A, 0, 1, 0, 1);
        chk("t1.valid_latency", 32'(u_if.out_valid), 1);
        chk("t1.data", 32'(u_if.out_data), 32'h032A);
        cyc(0, 8'h00, 0, 1, 0, 1);
        chk("t1.empty_after", 32'(empty), 1);

        // Capture in the same cycle as an overflow from ext=5.
        cyc(0, 8'h00, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 1, 0, 1);
        cyc(1, 8'h00, 1, 1, 0, 1);
        chk("t2.data", 32'(u_if.out_data), 32'h0600);
        cyc(1, 8'h01, 0, 1, 0, 1);
        chk("t2.popped", 32'(last_pop), 32'h0600);
        chk("t2.ext6", 32'(u_if.out_data), 32'h0601);
        cyc(0, 8'h00, 0, 1, 0, 1);

        // Six captures with no drain: four stored, two dropped.
        for (int i = 0; i < 6; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 0, 1);
        chk("t3.full", 32'(full), 1);
        chk("t3.level", 32'(level), 4);
        chk("t3.drop", 32'(drop_cnt), 2);
        chk("t3.head", 32'(u_if.out_data), 32'h0610);

        // Capture while full and draining: accepted, no drop, lands last.
        cyc(1, 8'h77, 0, 1, 0, 1);
        chk("t4.level", 32'(level), 4);
        chk("t4.drop", 32'(drop_cnt), 2);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 1, 0, 1);
        chk("t4.last", 32'(last_pop), 32'h0677);

        // 256 overflows bring the extension back to its starting value.
        cyc(0, 8'h00, 0, 1, 1, 1);
        for (int i = 0; i < 256; i++) cyc(0, 8'h00, 1, 1, 0, 0);
        cyc(1, 8'h5C, 0, 1, 0, 1);
        chk("t5.wrap", 32'(u_if.out_data), 32'h005C);
        cyc(0, 8'h00, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 8'h20, 0, 0, 0, 1);
        for (int i = 0; i < 260; i++) cyc(1, 8'h21, 0, 0, 0, 0);
        chk_state("t5.sat");
        chk("t5.drop_sat", 32'(drop_cnt), 255);

        // Clear with three entries and a capture pending.
        cyc(0, 8'h00, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 8'h30 + 8'(i), 1, 0, 0, 1);
        chk("t6.level3", 32'(level), 3);
        cyc(1, 8'h40, 1, 0, 1, 1);
        chk("t6.level0", 32'(level), 0);
        chk("t6.valid0", 32'(u_if.out_valid), 0);
        chk("t6.drop0", 32'(drop_cnt), 0);
        cyc(1, 8'h05, 0, 0, 0, 1);
        chk("t6.ext0", 32'(u_if.out_data), 32'h0005);

        // Asynchronous reset mid-drain, between clock edges.
        cyc(1, 8'h06, 0, 0, 0, 1);
        cyc(0, 8'h00, 0, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_ext  = '0;
        m_drop = '0;
        chk("rst2.valid", 32'(u_if.out_valid), 0);
        chk("rst2.data", 32'(u_if.out_data), 0);
        chk("rst2.level", 32'(level), 0);
        chk("rst2.empty", 32'(empty), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1, 8'h09, 0, 0, 0, 1);
        chk("rst2.ext0", 32'(u_if.out_data), 32'h0009);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
